// File: rtl/atmr_vote_ctrl.sv
// rtl/atmr_vote_ctrl.sv - majority vote and replica retirement controller for a triple-replica datapath
//
// Registers the three replica words each accepted sample and presents the
// voted (TMR/FAIL) or selected (DEGRADED) word one cycle later. A replica is
// retired once it mismatches for THRESH consecutive accepted samples. A
// req/ack clear returns the block to TMR with all fault history wiped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 replica words valid this cycle
//   ori_in, mai_in, men_in   replica 0/1/2 output words
//   out_valid                one-cycle pulse per accepted sample
//   z                        voted/selected word
//   mism                     per-replica mismatch on last sample {men,mai,ori}
//   fault                    sticky retired-replica flags
//   mode                     0=TMR, 1=DEGRADED, 2=FAIL
//   alarm                    sticky, set on entry to FAIL
//   evt_cnt                  saturating count of samples with any mismatch
//   clr_req, clr_ack         clear request level / one-cycle acknowledge

module atmr_vote_ctrl #(
    parameter int               WIDTH      = 10,
    parameter int               THRESH     = 4,
    parameter int               CNT_W      = 8,
    parameter logic [WIDTH-1:0] CHECK_MASK = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ori_in,
    input  logic [WIDTH-1:0] mai_in,
    input  logic [WIDTH-1:0] men_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] z,
    output logic [2:0]       mism,
    output logic [2:0]       fault,
    output logic [1:0]       mode,
    output logic             alarm,
    output logic [CNT_W-1:0] evt_cnt,
    input  logic             clr_req,
    output logic             clr_ack
);

    typedef enum logic [1:0] {
        MODE_TMR  = 2'd0,
        MODE_DEG  = 2'd1,
        MODE_FAIL = 2'd2
    } mode_t;

    mode_t                   mode_q, mode_d;
    logic [2:0][CNT_W-1:0]   run_q, run_d;
    logic                    clr_block_q;

    logic [2:0][WIDTH-1:0]   rep;
    logic [WIDTH-1:0]        vote;
    logic                    d01, d02, d12, pair_diff;
    logic                    clr_go, accept;
    logic [2:0]              mis;
    logic [1:0]              n_fault;

    logic                    out_valid_d, alarm_d, clr_ack_d;
    logic [WIDTH-1:0]        z_d;
    logic [2:0]              mism_d, fault_d;
    logic [CNT_W-1:0]        evt_d;

    assign mode = mode_q;

    always_comb begin
        rep  = {men_in, mai_in, ori_in};
        vote = (ori_in & mai_in) | (ori_in & men_in) | (mai_in & men_in);

        d01 = |((ori_in ^ mai_in) & CHECK_MASK);
        d02 = |((ori_in ^ men_in) & CHECK_MASK);
        d12 = |((mai_in ^ men_in) & CHECK_MASK);

        // With one replica retired the vote is no longer meaningful, so the
        // two survivors are compared against each other and both are blamed.
        case (fault)
            3'b001:  pair_diff = d12;
            3'b010:  pair_diff = d02;
            3'b100:  pair_diff = d01;
            default: pair_diff = 1'b0;
        endcase

        // A clear only fires on a fresh request so a held level cannot
        // repeatedly wipe state.
        clr_go = clr_req & ~clr_block_q;
        accept = in_valid & ~clr_go;

        for (int r = 0; r < 3; r++) begin
            if (mode_q == MODE_DEG) begin
                mis[r] = ~fault[r] & pair_diff;
            end else begin
                mis[r] = ~fault[r] & (|((rep[r] ^ vote) & CHECK_MASK));
            end
        end

        mode_d      = mode_q;
        run_d       = run_q;
        fault_d     = fault;
        z_d         = z;
        mism_d      = mism;
        alarm_d     = alarm;
        evt_d       = evt_cnt;
        out_valid_d = 1'b0;
        clr_ack_d   = 1'b0;
        n_fault     = 2'd0;

        if (clr_go) begin
            mode_d    = MODE_TMR;
            run_d     = '0;
            fault_d   = 3'b000;
            mism_d    = 3'b000;
            alarm_d   = 1'b0;
            evt_d     = '0;
            clr_ack_d = 1'b1;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                if (!fault[r]) begin
                    if (mis[r]) begin
                        if (run_q[r] != {CNT_W{1'b1}}) begin
                            run_d[r] = run_q[r] + 1'b1;
                        end
                        if (run_d[r] == CNT_W'(THRESH)) begin
                            fault_d[r] = 1'b1;
                        end
                    end else begin
                        run_d[r] = '0;
                    end
                end
            end

            n_fault = 2'(fault_d[0]) + 2'(fault_d[1]) + 2'(fault_d[2]);

            // FAIL is absorbing; otherwise the mode follows the fault count,
            // so a double retirement from TMR lands directly in FAIL.
            if (mode_q != MODE_FAIL) begin
                if (n_fault >= 2'd2) begin
                    mode_d = MODE_FAIL;
                end else if (n_fault == 2'd1) begin
                    mode_d = MODE_DEG;
                end else begin
                    mode_d = MODE_TMR;
                end
            end

            if (mode_d == MODE_FAIL) begin
                alarm_d = 1'b1;
            end

            // Output selection already follows the mode entered on this edge.
            if (mode_d == MODE_DEG) begin
                if (!fault_d[0]) begin
                    z_d = ori_in;
                end else if (!fault_d[1]) begin
                    z_d = mai_in;
                end else begin
                    z_d = men_in;
                end
            end else begin
                z_d = vote;
            end

            if ((mis != 3'b000) && (evt_cnt != {CNT_W{1'b1}})) begin
                evt_d = evt_cnt + 1'b1;
            end

            mism_d      = mis;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_TMR;
            run_q       <= '0;
            clr_block_q <= 1'b0;
            out_valid   <= 1'b0;
            z           <= '0;
            mism        <= 3'b000;
            fault       <= 3'b000;
            alarm       <= 1'b0;
            evt_cnt     <= '0;
            clr_ack     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            run_q       <= run_d;
            clr_block_q <= clr_req;
            out_valid   <= out_valid_d;
            z           <= z_d;
            mism        <= mism_d;
            fault       <= fault_d;
            alarm       <= alarm_d;
            evt_cnt     <= evt_d;
            clr_ack     <= clr_ack_d;
        end
    end

endmodule

// File: tb/tb_atmr_vote_ctrl.sv
// tb/tb_atmr_vote_ctrl.sv - scoreboard bench for atmr_vote_ctrl, full-mask and bit0-masked instances

module tb_atmr_vote_ctrl;

    localparam int W = 10;
    localparam int THRESH = 4;

    typedef struct {
        bit         is_clr;
        logic [9:0] z;
        logic [2:0] mism;
        logic [2:0] fault;
        logic [1:0] mode;
        bit         alarm;
        logic [7:0] evt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic clr_req = 1'b0;
    logic [W-1:0] ori_in = '0, mai_in = '0, men_in = '0;

    logic         ov_f, ov_m, al_f, al_m, ack_f, ack_m;
    logic [W-1:0] z_f, z_m;
    logic [2:0]   mi_f, mi_m, fl_f, fl_m;
    logic [1:0]   md_f, md_m;
    logic [7:0]   ev_f, ev_m;

    int checks = 0;
    int errors = 0;

    exp_t q_f[$];
    exp_t q_m[$];

    int         m_run[2][3];
    logic [2:0] m_flt[2];
    int         m_md[2];
    bit         m_alm[2];
    int         m_evt[2];
    bit         m_clr_prev;

    always #5 clk = ~clk;

    atmr_vote_ctrl #(.WIDTH(W), .THRESH(THRESH), .CNT_W(8), .CHECK_MASK(10'h3FF)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ori_in(ori_in), .mai_in(mai_in), .men_in(men_in),
        .out_valid(ov_f), .z(z_f), .mism(mi_f), .fault(fl_f), .mode(md_f),
        .alarm(al_f), .evt_cnt(ev_f), .clr_req(clr_req), .clr_ack(ack_f)
    );

    atmr_vote_ctrl #(.WIDTH(W), .THRESH(THRESH), .CNT_W(8), .CHECK_MASK(10'h3FE)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ori_in(ori_in), .mai_in(mai_in), .men_in(men_in),
        .out_valid(ov_m), .z(z_m), .mism(mi_m), .fault(fl_m), .mode(md_m),
        .alarm(al_m), .evt_cnt(ev_m), .clr_req(clr_req), .clr_ack(ack_m)
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual %0h required %0h at %0t", name, k, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 3; r++) m_run[k][r] = 0;
            m_flt[k] = 3'b000;
            m_md[k]  = 0;
            m_alm[k] = 0;
            m_evt[k] = 0;
        end
        m_clr_prev = 0;
    endtask

    // Reference behaviour from the operating rules: healthy list, vote or
    // pairwise comparison, run lengths, and mode from the number of retirements.
    task automatic model_step(input int k, input bit v, input logic [9:0] o, input logic [9:0] a,
                              input logic [9:0] m, input bit c);
        exp_t       e;
        logic [9:0] rep[3];
        logic [9:0] msk;
        logic [9:0] vote;
        logic [2:0] mis;
        int         h[$];
        int         nf;
        bit         found;
        msk = (k == 0) ? 10'h3FF : 10'h3FE;
        rep[0] = o; rep[1] = a; rep[2] = m;
        e = '{default: 0};
        if (c && !m_clr_prev) begin
            for (int r = 0; r < 3; r++) m_run[k][r] = 0;
            m_flt[k] = 3'b000;
            m_md[k]  = 0;
            m_alm[k] = 0;
            m_evt[k] = 0;
            e.is_clr = 1;
            if (k == 0) q_f.push_back(e); else q_m.push_back(e);
        end else if (v) begin
            vote = (o & a) | (o & m) | (a & m);
            mis = 3'b000;
            for (int r = 0; r < 3; r++) if (!m_flt[k][r]) h.push_back(r);
            if (m_md[k] == 1) begin
                if (((rep[h[0]] ^ rep[h[1]]) & msk) != 0) begin
                    mis[h[0]] = 1'b1;
                    mis[h[1]] = 1'b1;
                end
            end else begin
                foreach (h[i]) if (((rep[h[i]] ^ vote) & msk) != 0) mis[h[i]] = 1'b1;
            end
            foreach (h[i]) begin
                if (mis[h[i]]) begin
                    if (m_run[k][h[i]] < 255) m_run[k][h[i]]++;
                    if (m_run[k][h[i]] == THRESH) m_flt[k][h[i]] = 1'b1;
                end else begin
                    m_run[k][h[i]] = 0;
                end
            end
            nf = $countones(m_flt[k]);
            if (m_md[k] != 2) m_md[k] = (nf >= 2) ? 2 : nf;
            if (m_md[k] == 2) m_alm[k] = 1;
            if (mis != 0 && m_evt[k] < 255) m_evt[k]++;
            e.z = vote;
            if (m_md[k] == 1) begin
                found = 0;
                for (int r = 0; r < 3; r++) begin
                    if (!found && !m_flt[k][r]) begin
                        e.z = rep[r];
                        found = 1;
                    end
                end
            end
            e.mism  = mis;
            e.fault = m_flt[k];
            e.mode  = 2'(m_md[k]);
            e.alarm = m_alm[k];
            e.evt   = 8'(m_evt[k]);
            if (k == 0) q_f.push_back(e); else q_m.push_back(e);
        end
    endtask

    task automatic cycle(input bit v, input logic [9:0] o, input logic [9:0] a,
                         input logic [9:0] m, input bit c);
        @(negedge clk);
        in_valid = v;
        ori_in   = o;
        mai_in   = a;
        men_in   = m;
        clr_req  = c;
        model_step(0, v, o, a, m, c);
        model_step(1, v, o, a, m, c);
        m_clr_prev = c;
    endtask

    task automatic observe(input int k, input logic ov, input logic ack, input logic [9:0] zz,
                           input logic [2:0] mi, input logic [2:0] fl, input logic [1:0] md,
                           input logic al, input logic [7:0] ev);
        exp_t e;
        bit   empty;
        if (ov || ack) begin
            empty = (k == 0) ? (q_f.size() == 0) : (q_m.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output dut%0d out_valid %0b clr_ack %0b with nothing expected", k, ov, ack);
            end else begin
                e = (k == 0) ? q_f.pop_front() : q_m.pop_front();
                chk("clr_ack", k, 32'(ack), 32'(e.is_clr));
                chk("out_valid", k, 32'(ov), 32'(!e.is_clr));
                if (!e.is_clr) chk("z", k, 32'(zz), 32'(e.z));
                chk("mism", k, 32'(mi), 32'(e.mism));
                chk("fault", k, 32'(fl), 32'(e.fault));
                chk("mode", k, 32'(md), 32'(e.mode));
                chk("alarm", k, 32'(al), 32'(e.alarm));
                chk("evt_cnt", k, 32'(ev), 32'(e.evt));
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, ov_f, ack_f, z_f, mi_f, fl_f, md_f, al_f, ev_f);
        observe(1, ov_m, ack_m, z_m, mi_m, fl_m, md_m, al_m, ev_m);
    end

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 0, 32'(ov_f), 0);
        chk({tag, "_z"}, 0, 32'(z_f), 0);
        chk({tag, "_mism"}, 0, 32'(mi_f), 0);
        chk({tag, "_fault"}, 0, 32'(fl_f), 0);
        chk({tag, "_mode"}, 0, 32'(md_f), 0);
        chk({tag, "_alarm"}, 0, 32'(al_f), 0);
        chk({tag, "_evt_cnt"}, 0, 32'(ev_f), 0);
        chk({tag, "_clr_ack"}, 0, 32'(ack_f), 0);
        chk({tag, "_out_valid"}, 1, 32'(ov_m), 0);
        chk({tag, "_z"}, 1, 32'(z_m), 0);
        chk({tag, "_fault"}, 1, 32'(fl_m), 0);
        chk({tag, "_mode"}, 1, 32'(md_m), 0);
        chk({tag, "_evt_cnt"}, 1, 32'(ev_m), 0);
    endtask

    initial begin
        int         bad;
        int         hold;
        logic [9:0] b, o, a, m, flip;
        bit         c;

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Agreement
        repeat (20) cycle(1, 10'h155, 10'h155, 10'h155, 0);
        // Retire mai
        repeat (4) cycle(1, 10'h155, 10'h154, 10'h155, 0);
        repeat (5) cycle(1, 10'h155, 10'($urandom), 10'h155, 0);
        // Survivors disagree -> FAIL
        repeat (4) cycle(1, 10'h001, 10'($urandom), 10'h002, 0);
        repeat (2) cycle(0, 10'h0, 10'h0, 10'h0, 0);
        // Clear together with a sample, then held request lets samples through
        cycle(1, 10'($urandom), 10'($urandom), 10'($urandom), 1);
        repeat (2) cycle(1, 10'h155, 10'h155, 10'h155, 1);
        cycle(0, 10'h0, 10'h0, 10'h0, 0);
        // men differs only in bit 0
        repeat (10) cycle(1, 10'h155, 10'h155, 10'h154, 0);
        cycle(0, 10'h0, 10'h0, 10'h0, 1);
        cycle(0, 10'h0, 10'h0, 10'h0, 0);
        // Run reset by an intervening match
        repeat (3) cycle(1, 10'h155, 10'h154, 10'h155, 0);
        cycle(1, 10'h155, 10'h155, 10'h155, 0);
        repeat (3) cycle(1, 10'h155, 10'h154, 10'h155, 0);
        cycle(0, 10'h0, 10'h0, 10'h0, 1);
        cycle(0, 10'h0, 10'h0, 10'h0, 0);

        // Randomized traffic with a persistently bad replica per window
        bad  = 3;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) bad = int'($urandom_range(0, 3));
            b = 10'($urandom);
            o = b; a = b; m = b;
            if ($urandom_range(0, 9) < 7) begin
                flip = 10'(1) << $urandom_range(0, 9);
                case (bad)
                    0: o = o ^ flip;
                    1: a = a ^ flip;
                    2: m = m ^ flip;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 9) == 0) begin
                flip = 10'(1) << $urandom_range(0, 9);
                case ($urandom_range(0, 2))
                    0: o = o ^ flip;
                    1: a = a ^ flip;
                    default: m = m ^ flip;
                endcase
            end
            if (hold > 0) hold--;
            else if ($urandom_range(0, 29) == 0) hold = int'($urandom_range(1, 3));
            c = (hold > 0);
            cycle($urandom_range(0, 3) != 0, o, a, m, c);
        end

        // Asynchronous reset between clock edges while a sample is on the outputs
        cycle(1, 10'h2AA, 10'h2AA, 10'h2AB, 0);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        clr_req  = 1'b0;
        #1;
        check_zero("async_rst");
        q_f.delete();
        q_m.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        repeat (10) begin
            b = 10'($urandom);
            cycle(1, b, b, b, 0);
        end
        repeat (3) cycle(0, 10'h0, 10'h0, 10'h0, 0);
        chk("sb_drain", 0, 32'(q_f.size()), 0);
        chk("sb_drain", 1, 32'(q_m.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
